poly_bank_loader: RTL

//  Streams one polynomial (N coefficients, natural order) from a host valid/ready port into the 4 coefficient banks.

---
 rtl/kd_pkg.sv | 26 ++
 rtl/poly_lane_permute.sv | 24 ++
 rtl/poly_bank_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/kd_pkg.sv
// Shared loader/core definitions: default sizes, loader state encoding and
// the conflict-free coefficient-to-bank map.
package kd_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int N_DEF      = 256;
    localparam int ADDR_W_DEF = 7;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_FLUSH = 2'd2,
        LD_DONE  = 2'd3
    } ld_state_t;

    // Digit sum of the base-4 index, mod 4; Dilithium rotates the map by one.
    function automatic logic [1:0] bank_of(input logic [15:0] idx, input logic kd_mode);
        logic [1:0] s;
        s = {1'b0, kd_mode};
        for (int k = 0; k < 8; k++) begin
            s = s + idx[2*k +: 2];
        end
        return s;
    endfunction

endpackage

// File: rtl/poly_lane_permute.sv
// Combinational lane-to-bank crossbar for one row of four coefficients.
module poly_lane_permute
    import kd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ROW_W  = 6
) (
    input  logic [ROW_W-1:0]  row,
    input  logic              kd_mode,
    input  logic [DATA_W-1:0] lane [4],
    output logic [DATA_W-1:0] bank [4]
);

    // The map is a bijection within a row, so every bank is driven exactly once.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            bank[b] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            bank[bank_of(16'({row, 2'(i)}), kd_mode)] = lane[i];
        end
    end

endmodule

// File: rtl/poly_bank_loader.sv
// Streams one N-coefficient polynomial from a valid/ready host port into the
// four coefficient banks, one permuted row per write, then pulses load_done.
module poly_bank_loader
    import kd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N      = N_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              KD_mode,
    input  logic              load_start,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic [DATA_W-1:0] coef_data,
    input  logic              coef_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data0,
    output logic [DATA_W-1:0] wr_data1,
    output logic [DATA_W-1:0] wr_data2,
    output logic [DATA_W-1:0] wr_data3,
    output logic              load_done,
    output logic              load_err
);

    localparam int IDX_W = $clog2(N);
    localparam int ROW_W = IDX_W - 2;

    ld_state_t         state;
    logic [IDX_W-1:0]  idx;
    logic              kd_q;
    logic [DATA_W-1:0] fill_p0 [3];
    logic [DATA_W-1:0] row_lane [4];
    logic [DATA_W-1:0] bank_d [4];
    logic [1:0]        lane_sel;
    logic              accept;
    logic              at_end;
    logic              finish;
    logic              row_wr;

    assign lane_sel = idx[1:0];
    assign accept   = coef_valid & coef_ready;
    assign at_end   = (idx == IDX_W'(N - 1));
    assign finish   = accept & (at_end | coef_last);
    assign row_wr   = accept & ((lane_sel == 2'd3) | finish);

    // Lanes after the incoming word are zero so an early end pads its row.
    always_comb begin
        row_lane[0] = (lane_sel == 2'd0) ? coef_data : fill_p0[0];
        row_lane[1] = (lane_sel == 2'd1) ? coef_data :
                      (lane_sel >  2'd1) ? fill_p0[1] : '0;
        row_lane[2] = (lane_sel == 2'd2) ? coef_data :
                      (lane_sel == 2'd3) ? fill_p0[2] : '0;
        row_lane[3] = (lane_sel == 2'd3) ? coef_data : '0;
    end

    poly_lane_permute #(
        .DATA_W (DATA_W),
        .ROW_W  (ROW_W)
    ) u_permute (
        .row     (idx[IDX_W-1:2]),
        .kd_mode (kd_q),
        .lane    (row_lane),
        .bank    (bank_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LD_IDLE;
            idx        <= '0;
            kd_q       <= 1'b0;
            coef_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data0   <= '0;
            wr_data1   <= '0;
            wr_data2   <= '0;
            wr_data3   <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            for (int l = 0; l < 3; l++) begin
                fill_p0[l] <= '0;
            end
        end else begin
            wr_en     <= 1'b0;
            load_done <= 1'b0;
            // Row staging: write issues the cycle after the row's final accept
            if (row_wr) begin
                wr_en    <= 1'b1;
                wr_addr  <= ADDR_W'(idx[IDX_W-1:2]);
                wr_data0 <= bank_d[0];
                wr_data1 <= bank_d[1];
                wr_data2 <= bank_d[2];
                wr_data3 <= bank_d[3];
            end
            case (state)
                LD_IDLE: begin
                    if (load_start) begin
                        state      <= LD_LOAD;
                        idx        <= '0;
                        load_err   <= 1'b0;
                        kd_q       <= KD_mode;
                        coef_ready <= 1'b1;
                        for (int l = 0; l < 3; l++) begin
                            fill_p0[l] <= '0;
                        end
                    end
                end
                LD_LOAD: begin
                    if (accept) begin
                        case (lane_sel)
                            2'd0:    fill_p0[0] <= coef_data;
                            2'd1:    fill_p0[1] <= coef_data;
                            2'd2:    fill_p0[2] <= coef_data;
                            default: ;
                        endcase
                        idx <= idx + IDX_W'(1);
                        if (finish) begin
                            state      <= LD_FLUSH;
                            coef_ready <= 1'b0;
                            if (!at_end) begin
                                load_err <= 1'b1;
                            end
                        end
                    end
                end
                LD_FLUSH: begin
                    state     <= LD_DONE;
                    load_done <= 1'b1;
                end
                LD_DONE: begin
                    state <= LD_IDLE;
                end
                default: begin
                    state <= LD_IDLE;
                end
            endcase
        end
    end

endmodule
